// File: rtl/mc_control_unit.sv
// Multi-cycle RV32 control FSM: decodes IR fields into datapath strobes.
// Optional memory handshake/timeout enabled by MCU_MEM_HANDSHAKE_EN.
module mc_control_unit #(
  parameter int ALUC_W     = 4,
  parameter int TMO_CYCLES = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [3:0]        state,
  output logic              halted,
  output logic              illegal,
  output logic              mem_timeout,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        result_src,
  output logic [2:0]        imm_src,
  output logic [ALUC_W-1:0] alu_control
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_EX_J    = 4'd5,
    S_EX_B    = 4'd6,
    S_EX_U    = 4'd7,
    S_MEM_RD  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_WB_ALU  = 4'd10,
    S_WB_MEM  = 4'd11,
    S_HALT    = 4'd12,
    S_TRAP    = 4'd13
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  state_e     state_q, state_d;
  logic [3:0] alu_op;
  logic       rdy;

  function automatic logic [3:0] f3_op(
    input logic [2:0] f3,
    input logic       sub,
    input logic       sra
  );
    case (f3)
      3'b000:  return sub ? 4'd1 : 4'd0;
      3'b001:  return 4'd2;
      3'b010:  return 4'd3;
      3'b011:  return 4'd4;
      3'b100:  return 4'd5;
      3'b101:  return sra ? 4'd7 : 4'd6;
      3'b110:  return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

`ifdef MCU_MEM_HANDSHAKE_EN
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;
  assign rdy = mem_ready;
`else
  logic unused_ready;
  assign unused_ready = mem_ready;
  assign rdy          = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = 3'b000;
    alu_op     = 4'd0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b10;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (opcode == OP_BR)  imm_src = 3'b010;
        if (opcode == OP_JAL) imm_src = 3'b100;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_EX_ADDR;
          OP_IMM:         state_d = S_EX_I;
          OP_R:           state_d = S_EX_R;
          OP_LUI, OP_AUI: state_d = S_EX_U;
          OP_JAL:         state_d = S_EX_J;
          OP_BR:          state_d = S_EX_B;
          OP_SYS:         state_d = S_HALT;
          default:        state_d = S_TRAP;
        endcase
      end
      S_EX_R: begin
        alu_src_a = 2'b10;
        alu_op    = f3_op(funct3, funct7b5, funct7b5);
        state_d   = S_WB_ALU;
      end
      S_EX_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = f3_op(funct3, 1'b0, funct7b5);
        state_d   = S_WB_ALU;
      end
      S_EX_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_SW) ? 3'b001 : 3'b000;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_EX_U: begin
        alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b011;
        state_d   = S_WB_ALU;
      end
      S_EX_J: begin
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_EX_B: begin
        alu_src_a = 2'b10;
        alu_op    = 4'd1;
        pc_src    = 1'b1;
        state_d   = S_FETCH;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          default: state_d  = S_TRAP;
        endcase
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (rdy) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        state_d    = S_FETCH;
      end
      S_HALT, S_TRAP: state_d = state_q;
      default:        state_d = S_FETCH;
    endcase
`ifdef MCU_MEM_HANDSHAKE_EN
    cnt_d = '0;
    tmo_d = tmo_q;
    if ((state_q == S_FETCH || state_q == S_MEM_RD ||
         state_q == S_MEM_WR) && !mem_ready) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == 8'(TMO_CYCLES)) begin
        state_d = S_TRAP;
        tmo_d   = 1'b1;
      end
    end
    if (state_d != state_q) cnt_d = '0;
`endif
    // an aborted instruction must not leak strobes while reset is held
    if (!resetn) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

`ifdef MCU_MEM_HANDSHAKE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign mem_timeout = tmo_q;
`else
  assign mem_timeout = 1'b0;
`endif

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign illegal     = (state_q == S_TRAP);
  assign alu_control = ALUC_W'(alu_op);

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter ALUC_W, default 4, width of alu_control (minimum 4).
REQ-002 SHALL have parameter TMO_CYCLES, default 16, memory wait cycles before timeout trap (1..255).
REQ-003 clk  input  1  rising-edge clock; resetn  input  1  reset, asynchronous and active-low.
REQ-004 opcode[6:0], funct3[2:0], funct7b5 (1), zero (1, ALU zero flag), mem_ready (1): inputs taken from the IR and ALU.
REQ-005 state  output  4  current state; halted, illegal, mem_timeout  output  1 each  sticky status flags.
REQ-006 mem_read, mem_write, reg_write, ir_write, pc_write, pc_src  output  1 each  datapath strobes; pc_src 0 = ALU result, 1 = ALUOut.
REQ-007 alu_src_a[1:0] (00 PC, 01 oldPC, 10 rs1, 11 zero), alu_src_b[1:0] (00 rs2, 01 imm, 10 const 4), result_src[1:0] (00 ALUOut, 01 MDR), imm_src[2:0] (000 I, 001 S, 010 B, 011 U, 100 J), alu_control[ALUC_W-1:0]  outputs.

Function
REQ-010 States SHALL be: FETCH=0, DECODE=1, EX_R=2, EX_I=3, EX_ADDR=4, EX_J=5, EX_B=6, EX_U=7, MEM_RD=8, MEM_WR=9, WB_ALU=10, WB_MEM=11, HALT=12, TRAP=13; the undefined encodings 14-15 SHALL go to FETCH.
REQ-011 ALU codes SHALL be: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, zero-extended to ALUC_W.
REQ-012 FETCH SHALL assert mem_read, ir_write and pc_write with PC+4 (src_a 00, src_b 10, ADD), then go to DECODE.
REQ-013 DECODE SHALL compute oldPC+imm (imm_src B for BRANCH, J for JAL) into ALUOut, and dispatch as follows:
- LW/SW go to EX_ADDR.
- OP-IMM goes to EX_I; OP goes to EX_R.
- LUI/AUIPC go to EX_U.
- JAL goes to EX_J; BRANCH goes to EX_B.
- 1110011 goes to HALT.
- Any other opcode goes to TRAP.
REQ-014 The ALU operation SHALL come from funct3 in both EX_R and EX_I:
- funct3 000 selects SUB when funct7b5=1 in EX_R only; otherwise ADD.
- funct3 101 selects SRA when funct7b5=1 in both EX_R and EX_I; otherwise SRL.
REQ-015 EX_ADDR SHALL compute rs1+imm (I for LW, S for SW), then go to MEM_RD for LW or MEM_WR for SW.
REQ-016 EX_U SHALL compute imm_U plus zero (LUI) or oldPC (AUIPC), then go to WB_ALU.
REQ-017 EX_J SHALL assert pc_write with pc_src=1 and compute oldPC+4, then go to WB_ALU.
REQ-018 EX_B SHALL compute rs1 SUB rs2 with pc_src=1, and SHALL go to FETCH; pc_write SHALL be zero for BEQ (funct3 000) and ~zero for BNE (001); any other funct3 SHALL go to TRAP with no pc_write.
REQ-019 MEM_RD SHALL assert mem_read and go to WB_MEM; MEM_WR SHALL assert mem_write and go to FETCH.
REQ-020 WB_ALU SHALL assert reg_write with result_src 00; WB_MEM SHALL assert reg_write with result_src 01; both SHALL then go to FETCH.
REQ-021 HALT SHALL set halted, TRAP SHALL set illegal, and neither state SHALL be left except by reset; all strobes SHALL be 0 in both.
REQ-022 All outputs SHALL be decoded combinationally from state plus the decode inputs; unused outputs SHALL be 0.

Reset
REQ-030 resetn low SHALL asynchronously force state to FETCH, clear all flags and clear the wait counter.
REQ-031 Reset asserted mid-instruction SHALL abort the instruction with no further strobes; the first cycle after release SHALL be FETCH.

Configuration
REQ-040 With MCU_MEM_HANDSHAKE_EN defined, the memory wait and timeout behaviour SHALL be as follows:
- FETCH, MEM_RD and MEM_WR SHALL hold until mem_ready=1.
- While holding, ir_write and pc_write SHALL be gated by mem_ready.
- An 8-bit wait counter SHALL count stall cycles and clear on every state change.
- When the counter reaches TMO_CYCLES, the block SHALL go to TRAP and set mem_timeout.
REQ-041 Without MCU_MEM_HANDSHAKE_EN, mem_ready SHALL be ignored, every state SHALL last one cycle, and mem_timeout SHALL stay 0.

Verification
REQ-050 Verification SHALL cover the following directed scenarios:
- ADD (opcode 0110011, funct3 000, funct7b5 0): states 0,1,2,10,0; alu_control 0 in EX_R; reg_write for one cycle.
- SUB (same fields, funct7b5 1): alu_control 1 in EX_R.
- LW: states 0,1,4,8,11,0; mem_read in MEM_RD; result_src 01 in WB_MEM.
- BNE with zero=0: pc_write=1 in EX_B. BNE with zero=1: pc_write=0. funct3 100: TRAP and illegal=1.
- Handshake on, mem_ready held 0 in MEM_WR for 16 cycles: TRAP, mem_timeout=1. mem_ready rising at cycle 3: exit to FETCH.
- EBREAK: halted=1 and state stays 12. resetn pulsed low mid-EX_I: state 0 immediately, all flags 0.
